stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//   Parametrised N-to-1 streaming multiplexer with round-robin arbitration.
//   Selects one of N_IN valid/ready input channels each cycle and drives a registered output stage.
//   Successor to the fixed combinational mux trees, for shared datapaths where several producers feed one consumer.
//   Adds flow control and fairness.
// PARAMETERS
//   N_IN   4   number of input channels (>=2, power of two not required)
//   WIDTH  4   data width per channel in bits
//   SEL_W  $clog2(N_IN)  localparam, width of channel index
// PORTS
//   clk        in   1            clock, all state on rising edge
//   rst        in   1            synchronous reset, active-high
//   in_valid   in   N_IN         per-channel valid
//   in_data    in   N_IN*WIDTH   packed data; channel i = in_data[i*WIDTH +: WIDTH]
//   in_ready   out  N_IN         per-channel ready; at most one bit set
//   out_valid  out  1            output register holds data
//   out_data   out  WIDTH        registered data of the granted channel
//   out_sel    out  SEL_W        index of the channel that supplied out_data
//   out_ready  in   1            consumer accepts out_data this cycle
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
//     A pending output word is discarded; no input transfer occurs in the reset cycle.
//   - Combinational load_en = !out_valid | out_ready. in_ready is forced to 0 while rst=1.
//   - Grant g = first i with in_valid[i], scanning ptr, ptr+1, ..., N_IN-1, 0, ..., ptr-1 (mod N_IN).
//   - in_ready = onehot(g) when load_en and any in_valid, else all zero.
//     in_ready depends on in_valid, out_valid, out_ready and ptr only.
//   - Input transfer on channel i: in_valid[i] & in_ready[i] at clk edge. At that edge:
//     out_data <= channel g data, out_sel <= g, out_valid <= 1, ptr <= (g==N_IN-1) ? 0 : g+1.
//   - load_en with no in_valid: out_valid <= 0, out_data/out_sel hold, ptr holds.
//   - !load_en (out_valid & !out_ready): out_valid, out_data, out_sel, ptr all hold.
//     Output is stable under backpressure.
//   - Latency: 1 cycle from input transfer to out_valid.
//     Throughput: 1 word/cycle while out_ready=1.
//   - Fairness: a channel held valid is granted within N_IN output transfers.
//   - Pointer wrap: for non-power-of-two N_IN, ptr never exceeds N_IN-1.
//   - Simultaneous output drain and input load in one cycle is a normal transfer with no bubble.
//   - Inputs are not required to hold data stable while waiting. Only the granted channel is sampled.
// TESTING
//   1. Reset: rst=1 for 2 cycles, all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
//   2. Single channel: in_valid=4'b0100, data ch2=0xC, out_ready=1 -> next cycle out_valid=1, out_data=0xC, out_sel=2.
//      in_ready=4'b0100 every cycle.
//   3. Round robin: in_valid=4'b1111, data ch i = 0xA+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,1.
//      out_data sequence A,B,C,D,A,B.
//   4. Backpressure: hold out_ready=0 for 3 cycles after out_valid=1 (sel=1, data=0xB) -> out_* unchanged, in_ready=0.
//      On out_ready=1 the next grant is ch2.
//   5. Wrap, N_IN=3: in_valid=3'b101, ptr=0 -> grants 0,2,0,2. ptr never equals 3.
//   6. Reset mid-stream: rst=1 while out_valid=1, out_ready=0 -> out_valid=0 next cycle.
//      After release with all valid, first out_sel=0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_IN-to-1 valid/ready stream multiplexer with a round-robin grant
// and a single registered output stage that holds its word under backpressure.
module stream_mux_rr #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 4,
    localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    logic             w_load_en;
    logic             w_any;
    logic             w_fire;
    logic [SEL_W-1:0] w_grant;
    logic [N_IN-1:0]  w_one;
    int               w_idx;

    assign w_load_en = !r_out_valid | out_ready;
    assign w_any     = |in_valid;
    assign w_fire    = w_load_en & w_any & !rst;
    assign w_one     = {{(N_IN-1){1'b0}}, 1'b1};

    // Scan from the lowest priority position down to ptr so the last hit wins.
    always_comb begin
        w_grant = '0;
        w_idx   = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_IN) begin
                w_idx = w_idx - N_IN;
            end
            if (in_valid[SEL_W'(w_idx)]) begin
                w_grant = SEL_W'(w_idx);
            end
        end
    end

    assign in_ready = w_fire ? (w_one << w_grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_grant*WIDTH +: WIDTH];
                r_out_sel   <= w_grant;
                // Explicit wrap keeps ptr inside 0..N_IN-1 for non-power-of-two N_IN.
                r_ptr       <= (w_grant == SEL_W'(N_IN - 1)) ? '0 : w_grant + 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: expected words go into per-DUT queues,
// monitors pop and compare whenever an output transfer is presented.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    logic [2:0]  in_valid3;
    logic [11:0] in_data3;
    logic [2:0]  in_ready3;
    logic        out_valid3;
    logic [3:0]  out_data3;
    logic [1:0]  out_sel3;
    logic        out_ready3;

    int n_chk  = 0;
    int n_fail = 0;
    int q4[$];
    int q3[$];

    always #5 clk = ~clk;

    stream_mux_rr #(.N_IN(4), .WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.N_IN(3), .WIDTH(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
        .out_ready(out_ready3)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected words are encoded as {sel, data} = sel*16 + data.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mon4_unexpected: got sel=%0d data=0x%0h expected nothing", out_sel, out_data);
            end else begin
                check("mon4_word", int'({out_sel, out_data}), q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mon3_unexpected: got sel=%0d data=0x%0h expected nothing", out_sel3, out_data3);
            end else begin
                check("mon3_word", int'({out_sel3, out_data3}), q3.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 4'hF;
        in_data    = 16'hDCBA;
        out_ready  = 1'b1;
        in_valid3  = 3'b000;
        in_data3   = 12'h951;
        out_ready3 = 1'b1;

        // Reset with every channel requesting
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_in_ready", int'(in_ready), 0);
            step();
        end
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sel", int'(out_sel), 0);

        // Single channel 2 streaming
        rst      = 1'b0;
        in_valid = 4'b0100;
        in_data  = 16'h0C00;
        for (int i = 0; i < 3; i++) begin
            q4.push_back(8'h2C);
            @(negedge clk);
            check("single_in_ready", int'(in_ready), 4'b0100);
            step();
        end
        in_valid = 4'b0000;
        step();
        check("single_drained", int'(out_valid), 0);

        rst = 1'b1;
        step();
        rst = 1'b0;

        // Round robin over all four channels
        in_valid = 4'hF;
        in_data  = 16'hDCBA;
        for (int i = 0; i < 6; i++) begin
            int g;
            g = i % 4;
            q4.push_back(g * 16 + 10 + g);
            @(negedge clk);
            check("rr_in_ready", int'(in_ready), 1 << g);
            step();
        end

        // Backpressure holding sel=1 / data=B
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_word", int'({out_sel, out_data}), 8'h1B);
            step();
        end
        out_ready = 1'b1;
        q4.push_back(8'h2C);
        @(negedge clk);
        check("bp_release_in_ready", int'(in_ready), 4'b0100);
        step();
        in_valid = 4'b0000;
        step();

        // Reset while a word is stalled in the output register
        in_valid  = 4'hF;
        out_ready = 1'b0;
        @(negedge clk);
        check("mid_in_ready", int'(in_ready), 4'b1000);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_pre_valid", int'(out_valid), 1);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        q4.push_back(8'h0A);
        @(negedge clk);
        check("mid_post_valid", int'(out_valid), 0);
        check("mid_post_in_ready", int'(in_ready), 4'b0001);
        step();
        in_valid = 4'b0000;
        step();

        // Three-channel wrap with channels 0 and 2 requesting
        in_valid3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = (i % 2 == 0) ? 0 : 2;
            q3.push_back(g * 16 + ((g == 0) ? 1 : 9));
            @(negedge clk);
            check("wrap_in_ready", int'(in_ready3), 1 << g);
            step();
        end
        in_valid3 = 3'b111;
        q3.push_back(8'h01);
        @(negedge clk);
        check("wrap_ptr_back_to0", int'(in_ready3), 3'b001);
        step();
        in_valid3 = 3'b000;
        step();
        step();

        check("q4_empty", q4.size(), 0);
        check("q3_empty", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
